// File: rtl/demux_seq_pkg.sv
// Shared types and sizes for the 1-to-8 demux sequencer.
package demux_seq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;
    localparam int HOLD_W = $clog2(16);
endpackage

// File: rtl/demux_sequencer_hold_timer.sv
// Per-channel hold counter; expire marks the last cycle a channel is driven.
module hold_timer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == HOLD_W'(HOLD_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = expire ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/demux_sequencer.sv
// Serialises an 8-bit word onto a 1-to-8 demux, one channel per HOLD_CYCLES.
module demux_sequencer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       flush,
    output logic       EN,
    output logic       D,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic       busy,
    output logic       done
);
    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   ch_q, ch_d;
    logic                rdy_q;
    logic                expire;
    logic                driving;

    assign driving = (state_q == DRIVE);

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!driving || flush),
        .en     (driving),
        .expire (expire)
    );

    // rdy_q keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_q && (state_q == IDLE) && !flush;
    assign EN       = !driving;
    assign D        = driving ? word_q[ch_q] : 1'b0;
    assign {A2, A1, A0} = driving ? ch_q : '0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == GAP) && !flush;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = DRIVE;
                    word_d  = in_data;
                    ch_d    = '0;
                end
            end
            DRIVE: begin
                if (flush) begin
                    state_d = IDLE;
                    word_d  = '0;
                    ch_d    = '0;
                end else if (expire) begin
                    if (ch_q == ADDR_W'(NUM_CH - 1)) state_d = GAP;
                    else                             ch_d    = ch_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                word_d  = '0;
                ch_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            ch_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ch_q    <= ch_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_sequencer.sv
// Bench: two instances (HOLD_CYCLES=2 and 1) checked cycle by cycle against expected demux traces.
module tb_demux_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv  [2];
    logic       fl  [2];
    logic [7:0] id  [2];
    logic       rdy [2];
    logic       en  [2];
    logic       d   [2];
    logic       a2  [2];
    logic       a1  [2];
    logic       a0  [2];
    logic       bsy [2];
    logic       dn  [2];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    demux_sequencer #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
        .flush(fl[0]), .EN(en[0]), .D(d[0]), .A2(a2[0]), .A1(a1[0]), .A0(a0[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    demux_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
        .flush(fl[1]), .EN(en[1]), .D(d[1]), .A2(a2[1]), .A1(a1[1]), .A0(a0[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input int u, input string tag, input logic e_en, input logic e_d,
                           input logic [2:0] e_a, input logic e_b, input logic e_dn,
                           input logic e_rdy);
        chk({tag, ".EN"},       {7'd0, en[u]},  {7'd0, e_en});
        chk({tag, ".D"},        {7'd0, d[u]},   {7'd0, e_d});
        chk({tag, ".A"},        {5'd0, a2[u], a1[u], a0[u]}, {5'd0, e_a});
        chk({tag, ".busy"},     {7'd0, bsy[u]}, {7'd0, e_b});
        chk({tag, ".done"},     {7'd0, dn[u]},  {7'd0, e_dn});
        chk({tag, ".in_ready"}, {7'd0, rdy[u]}, {7'd0, e_rdy});
    endtask

    // Called at a negedge (or just after) with the instance idle. Expected trace:
    // 8*H DRIVE cycles with channel (c-1)/H, then GAP with done, then IDLE.
    task automatic send_word(input int u, input logic [7:0] w, input int flush_at,
                             input bit chg, input bit hold);
        int h;
        h = (u == 0) ? 2 : 1;
        iv[u] = 1'b1;
        id[u] = w;
        #1;
        chk("accept_ready", {7'd0, rdy[u]}, 8'd1);
        @(negedge clk);
        if (!hold) iv[u] = 1'b0;
        for (int c = 1; c <= 8 * h; c++) begin
            int ch;
            ch = (c - 1) / h;
            chk_out(u, $sformatf("drive_u%0d_c%0d", u, c), 1'b0, w[ch], ch[2:0], 1'b1, 1'b0, 1'b0);
            if (chg) id[u] = 8'($urandom);
            if (c == flush_at) begin
                fl[u] = 1'b1;
                @(negedge clk);
                fl[u] = 1'b0;
                #1;
                chk_out(u, "after_flush", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
                return;
            end
            @(negedge clk);
        end
        chk_out(u, "gap", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_out(u, "idle", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0; fl[u] = 1'b0; id[u] = 8'h00;
        end
        @(negedge clk);
        chk_out(0, "reset0", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_out(1, "reset1", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {7'd0, rdy[0]}, 8'd1);

        // Basic word, HOLD=2
        send_word(0, 8'hA5, 0, 1'b0, 1'b0);

        // Flush during channel 4 (cycles 9..10 at HOLD=2)
        send_word(0, 8'h3C, 9, 1'b0, 1'b0);

        // Flush and valid together in IDLE: flush wins
        iv[0] = 1'b1; id[0] = 8'h96; fl[0] = 1'b1;
        #1;
        chk("flush_idle_ready", {7'd0, rdy[0]}, 8'd0);
        @(negedge clk);
        chk_out(0, "flush_idle_noacc", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        fl[0] = 1'b0;
        send_word(0, 8'h96, 0, 1'b0, 1'b0);

        // Input data scrambled during DRIVE is ignored
        send_word(0, 8'h00, 0, 1'b1, 1'b0);
        send_word(0, 8'hFF, 0, 1'b1, 1'b0);

        // Random words, every other one flushed at a random cycle
        for (int i = 0; i < 6; i++)
            send_word(0, 8'($urandom), (i % 2 == 1) ? int'($urandom_range(1, 16)) : 0,
                      1'b1, 1'b0);

        // HOLD=1, valid held high: back-to-back words, each accepted after one IDLE cycle
        send_word(1, 8'hFF, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            send_word(1, 8'($urandom), 0, 1'b0, 1'b1);
        iv[1] = 1'b0;
        @(negedge clk);
        chk_out(1, "hold1_drained", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-DRIVE
        iv[0] = 1'b1; id[0] = 8'h5A;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", {7'd0, bsy[0]}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_out(0, "async_reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {7'd0, rdy[0]}, 8'd0);
        @(negedge clk);
        chk_out(0, "post_reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        send_word(0, 8'hC3, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/demux_sequencer.md
DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, giving clock cycles each channel is driven; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream word valid.
REQ-005 SHALL have port in_ready, output, 1, sequencer can accept a word.
REQ-006 SHALL have port in_data, input, 8, word to distribute; bit i goes to demux channel i.
REQ-007 SHALL have port flush, input, 1, synchronous abort of the current word.
REQ-008 SHALL have ports EN, D, A2, A1, A0, outputs, 1 each, driving the 1-to-8 demux:
  - EN: active-low enable; EN=1 disables the demux and tristates its outputs.
  - D: data bit.
  - A2..A0: channel address, A2 is the MSB.
REQ-009 SHALL have port busy, output, 1, high while a word is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a word completes.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-012 In IDLE: in_ready=1, EN=1, busy=0; handshake completes on a rising edge with in_valid=1 and in_ready=1.
REQ-013 On the accept edge SHALL register in_data, enter DRIVE, and set channel=0 and hold count=0.
REQ-014 Latency: EN SHALL go low in the first cycle after the accept edge, with A=0 and D=in_data[0].
REQ-015 In DRIVE: EN=0, {A2,A1,A0}=channel, D=word[channel], in_ready=0, busy=1.
REQ-016 Each channel SHALL be held exactly HOLD_CYCLES cycles; A and D SHALL change only on the same edge, never separately.
REQ-017 Channel counter SHALL advance 0..7 without skipping; after channel 7's last hold cycle the FSM SHALL enter GAP instead of wrapping to 0.
REQ-018 In GAP (exactly 1 cycle): EN=1, done=1, busy=1, in_ready=0; next state is IDLE.
REQ-019 A full word SHALL occupy 8*HOLD_CYCLES DRIVE cycles plus 1 GAP cycle; the next accept is possible at the earliest on the edge ending the first IDLE cycle.
REQ-020 in_data and in_valid SHALL be ignored outside IDLE; the latched word SHALL NOT change during DRIVE.
REQ-021 flush=1 in DRIVE or GAP SHALL force IDLE on the next edge: EN=1, no done pulse, word discarded.
REQ-022 flush=1 and in_valid=1 together in IDLE: flush wins; the word SHALL NOT be accepted, and in_ready SHALL be driven low in that cycle.
REQ-023 D SHALL be 0 and A SHALL be 0 whenever EN=1.
REQ-024 done SHALL never be high for two consecutive cycles.

Reset
REQ-025 On rst_n=0, asynchronously and independent of clk:
  - state=IDLE; EN=1, D=0, A2=A1=A0=0, busy=0, done=0.
  - in_ready=0 while rst_n=0, and 1 from the first edge after release.
REQ-026 Reset asserted mid-word SHALL abort the word immediately, with no done pulse.
REQ-027 Latched word, channel counter and hold counter SHALL all clear to 0.

Structure
REQ-028 A shared package demux_seq_pkg SHALL hold:
  - the state enum (IDLE, DRIVE, GAP);
  - NUM_CH=8 and ADDR_W=3;
  - HOLD_W = $clog2(16) width for the hold counter.
REQ-029 The hold counter SHALL be a sub-module hold_timer (inputs clk, rst_n, clr, en; output expire when count == HOLD_CYCLES-1); all other logic stays in demux_sequencer.

Verification
REQ-030 Reset: rst_n=0 mid-DRIVE -> EN=1, D=0, A=0, busy=0 without a clock edge; after release, in_ready=1 on the next edge.
REQ-031 Basic, HOLD_CYCLES=2, in_data=8'hA5 ->
  - channels 0..7 each held 2 cycles, D sequence 1,0,1,0,0,1,0,1;
  - GAP with done=1 at cycle 17 after accept;
  - IDLE at cycle 18.
REQ-032 HOLD_CYCLES=1, in_data=8'hFF, in_valid held high -> 8 DRIVE cycles, 1 GAP, then the next word is accepted on the edge ending the first IDLE cycle; no word is lost or duplicated.
REQ-033 flush asserted during channel 4 with in_data=8'h3C -> EN=1 next cycle, no done pulse, in_ready=1, A=0, D=0.
REQ-034 flush and in_valid both high in IDLE -> no accept, busy stays 0; the word is accepted the cycle after flush drops.
REQ-035 in_data changed during DRIVE (8'h00 -> 8'hFF) -> D still follows the original latched word through all 8 channels.
